// File: rtl/int_byte_link_pkg.sv
// rtl/int_byte_link_pkg.sv - shared types and helpers for the int-to-byte link
package int_byte_link_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // One byte on the link plus its end-of-word marker; the receive end uses the same layout.
   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              last;
   } byte_beat_t;

   // A requested byte count of zero means "the whole word".
   function automatic int eff_nbytes(input int n, input int nbytes);
      return (n == 0) ? nbytes : n;
   endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// rtl/byte_shift_reg.sv - word holding register that hands out one byte per shift
module byte_shift_reg
   import int_byte_link_pkg::*;
#(
   parameter int NBYTES    = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [NBYTES*BYTE_W-1:0]   load_word,
   input  logic [$clog2(NBYTES+1)-1:0] load_n,
   input  logic                       shift,
   output logic [BYTE_W-1:0]          head_byte
);

   localparam int W = NBYTES * BYTE_W;

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;
   int           shamt;

   // Load or advance the register; for MSB-first the selected bytes are left-aligned
   // on load so the head is always the top byte.
   always_comb begin
      data_d = data_q;
      shamt  = 0;
      if (load) begin
         if (MSB_FIRST != 0) begin
            shamt  = BYTE_W * (NBYTES - int'(load_n));
            data_d = load_word << shamt;
         end else begin
            data_d = load_word;
         end
      end else if (shift) begin
         if (MSB_FIRST != 0) begin
            data_d = data_q << BYTE_W;
         end else begin
            data_d = data_q >> BYTE_W;
         end
      end
   end

   // Register update with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign head_byte = (MSB_FIRST != 0) ? data_q[W-1 -: BYTE_W] : data_q[BYTE_W-1:0];

endmodule

// File: rtl/int_byte_serializer.sv
// rtl/int_byte_serializer.sv - splits signed words into a last-flagged byte stream
module int_byte_serializer
   import int_byte_link_pkg::*;
#(
   parameter int NBYTES    = 4,
   parameter int MSB_FIRST = 1,
   parameter int CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NBYTES*8-1:0]         in_word,
   input  logic [$clog2(NBYTES+1)-1:0] in_nbytes,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [7:0]                  out_byte,
   output logic                        out_last,
   output logic [CNT_W-1:0]            words_sent,
   output logic                        busy
);

   localparam int NW = $clog2(NBYTES + 1);

   state_e           state_q, state_d;
   logic [NW-1:0]    rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             init_q, init_d;

   logic             accept;
   logic             beat;
   logic [NW-1:0]    n_eff;
   logic [7:0]       head_byte;
   byte_beat_t       cur_beat;

   assign n_eff  = NW'(eff_nbytes(int'(in_nbytes), NBYTES));
   assign accept = in_valid & in_ready;
   assign beat   = out_valid & out_ready;

   // The current byte and its end-of-word flag, only meaningful while a word is held.
   always_comb begin
      cur_beat.data = 8'h00;
      cur_beat.last = 1'b0;
      if (state_q == SEND) begin
         cur_beat.data = head_byte;
         cur_beat.last = (rem_q == NW'(1));
      end
   end

   assign out_valid  = (state_q == SEND);
   assign busy       = (state_q == SEND);
   assign out_byte   = cur_beat.data;
   assign out_last   = cur_beat.last;
   assign words_sent = cnt_q;
   // Accepting on the final beat lets consecutive words stream without a bubble;
   // init_q holds in_ready low for the first cycle out of reset.
   assign in_ready   = init_q & ((state_q == IDLE) | (out_ready & cur_beat.last));

   // Next-state logic: load on acceptance, count down bytes, bump the word counter on the last beat.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      init_d  = 1'b1;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SEND;
               rem_d   = n_eff;
            end
         end
         SEND: begin
            if (beat) begin
               rem_d = rem_q - NW'(1);
               if (cur_beat.last) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (accept) begin
                     rem_d = n_eff;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset drops any word in flight and clears the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         init_q  <= init_d;
      end
   end

   byte_shift_reg #(
      .NBYTES    (NBYTES),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .load_word (in_word),
      .load_n    (n_eff),
      .shift     (beat),
      .head_byte (head_byte)
   );

   rem_nonzero_in_send: assert property (@(posedge clk) disable iff (rst)
      (state_q == SEND) |-> (rem_q != '0));

endmodule

// File: tb/tb_int_byte_serializer.sv
// tb/tb_int_byte_serializer.sv - scoreboard bench for MSB-first and LSB-first serializers
module tb_int_byte_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_word = 32'h0;
   logic [2:0]  in_nbytes = 3'd0;
   logic        out_ready = 1'b1;

   logic        in_ready_m, out_valid_m, out_last_m, busy_m;
   logic [7:0]  out_byte_m;
   logic [15:0] words_sent_m;
   logic        in_ready_l, out_valid_l, out_last_l, busy_l;
   logic [7:0]  out_byte_l;
   logic [1:0]  words_sent_l;

   int vectors = 0;
   int fails   = 0;
   int mode    = 0;
   int since   = 0;
   logic [31:0] exp_cnt = 32'h0;

   typedef struct {
      logic [7:0] bm;
      logic [7:0] bl;
      logic       last;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   int_byte_serializer #(.NBYTES(4), .MSB_FIRST(1), .CNT_W(16)) dut_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_word(in_word),
      .in_nbytes(in_nbytes), .out_valid(out_valid_m), .out_ready(out_ready), .out_byte(out_byte_m),
      .out_last(out_last_m), .words_sent(words_sent_m), .busy(busy_m)
   );

   int_byte_serializer #(.NBYTES(4), .MSB_FIRST(0), .CNT_W(2)) dut_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_word(in_word),
      .in_nbytes(in_nbytes), .out_valid(out_valid_l), .out_ready(out_ready), .out_byte(out_byte_l),
      .out_last(out_last_l), .words_sent(words_sent_l), .busy(busy_l)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference: the byte sequence a word produces in each byte order.
   task automatic push_word(input logic [31:0] w, input int n);
      int   ne;
      exp_t e;
      ne = (n == 0) ? 4 : n;
      for (int i = 0; i < ne; i++) begin
         e.bm   = w[8*(ne-1-i) +: 8];
         e.bl   = w[8*i +: 8];
         e.last = (i == ne - 1);
         q.push_back(e);
      end
   endtask

   // Called at posedge+2; returns at posedge+2 right after the accepting edge.
   task automatic send_word(input logic [31:0] w, input int n);
      logic rdy;
      in_valid  = 1'b1;
      in_word   = w;
      in_nbytes = 3'(n);
      for (int c = 0; c < 300; c++) begin
         #1;
         rdy = in_ready_m;
         @(posedge clk);
         if (rdy) begin
            push_word(w, n);
            #2;
            in_valid = 1'b0;
            in_word  = $urandom;
            return;
         end
         #2;
      end
      fails++;
      $display("FAIL accept_timeout at %0t: got no in_ready expected acceptance", $time);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Sink-side backpressure generator.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compares both DUTs against the scoreboard every cycle.
   initial begin
      exp_t e;
      logic exp_valid, exp_rdy;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            exp_cnt = 32'h0;
            since   = 0;
         end else begin
            if (since < 2) since++;
            exp_valid = (q.size() != 0);
            exp_rdy   = (since >= 2) && ((q.size() == 0) || ((q.size() == 1) && out_ready));
            chk("out_valid_msb", 32'(out_valid_m), 32'(exp_valid));
            chk("out_valid_lsb", 32'(out_valid_l), 32'(exp_valid));
            chk("busy_msb", 32'(busy_m), 32'(exp_valid));
            chk("busy_lsb", 32'(busy_l), 32'(exp_valid));
            chk("in_ready_msb", 32'(in_ready_m), 32'(exp_rdy));
            chk("in_ready_lsb", 32'(in_ready_l), 32'(exp_rdy));
            chk("words_sent_msb", 32'(words_sent_m), 32'(exp_cnt[15:0]));
            chk("words_sent_lsb", 32'(words_sent_l), 32'(exp_cnt[1:0]));
            if (q.size() != 0) begin
               e = q[0];
               chk("out_byte_msb", 32'(out_byte_m), 32'(e.bm));
               chk("out_byte_lsb", 32'(out_byte_l), 32'(e.bl));
               chk("out_last_msb", 32'(out_last_m), 32'(e.last));
               chk("out_last_lsb", 32'(out_last_l), 32'(e.last));
               if (out_ready) begin
                  void'(q.pop_front());
                  if (e.last) exp_cnt = exp_cnt + 1;
               end
            end else begin
               chk("idle_byte_msb", 32'(out_byte_m), 32'h0);
               chk("idle_byte_lsb", 32'(out_byte_l), 32'h0);
               chk("idle_last_msb", 32'(out_last_m), 32'h0);
               chk("idle_last_lsb", 32'(out_last_l), 32'h0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog at %0t: got no finish expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit drained;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;

      send_word(32'h12345678, 4);
      idle(6);

      send_word(32'hAABBCCDD, 2);
      idle(4);
      send_word(32'hAABBCCDD, 0);
      idle(6);

      send_word(32'hCAFEF00D, 4);
      send_word(32'h0BADBEEF, 4);
      idle(10);

      mode = 2;
      out_ready = 1'b1;
      send_word(32'h89ABCDEF, 4);
      idle(1);
      out_ready = 1'b0;
      idle(3);
      out_ready = 1'b1;
      mode = 0;
      idle(6);

      send_word(32'h13579BDF, 4);
      idle(2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(2);
      for (int k = 0; k < 5; k++) send_word(32'h01020304 + 32'(k), 4);
      idle(6);
      chk("wrap_words_lsb", 32'(words_sent_l), 32'h1);
      chk("words_msb_after5", 32'(words_sent_m), 32'h5);

      for (int k = 0; k < 60; k++) begin
         mode = int'($urandom_range(0, 1));
         send_word($urandom, int'($urandom_range(0, 4)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end

      mode = 0;
      drained = 1'b0;
      for (int c = 0; c < 100 && !drained; c++) begin
         idle(1);
         if (q.size() == 0) drained = 1'b1;
      end
      vectors++;
      if (!drained) begin
         fails++;
         $display("FAIL drain at %0t: got %0d pending bytes expected 0", $time, q.size());
      end
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
